merge_packer: RTL and testbench
===============================

Name: merge_packer

Overview:
- Sits directly downstream of the two-input merge stage.
- Consumes the merge stage's variable-length concatenated vector: up to IN_ELEMS elements of WIDTH bits, first element in the MSBs, plus a length field.
- Accumulates elements across cycles and emits fixed OUT_ELEMS-element words over a ready/valid interface toward the output FIFO/serializer.
- A flush request drains the residue as a zero-padded final word tagged out_last.

Parameters:
- WIDTH, 16, bits per element.
- IN_ELEMS, 20, maximum elements per input beat (merge LEN1+LEN2).
- OUT_ELEMS, 8, elements per output word.
- BUF_ELEMS, IN_ELEMS+OUT_ELEMS, internal buffer capacity in elements (derived, not overridable).

Ports:
- clock, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- in_data, input, WIDTH*IN_ELEMS, element k at bits [WIDTH*(IN_ELEMS-k)-1 : WIDTH*(IN_ELEMS-k-1)].
- in_len, input, MinBitWidth(IN_ELEMS), number of valid leading elements.
- in_valid, input, 1, input beat present.
- in_ready, output, 1, beat accepted when in_valid && in_ready.
- flush, input, 1, request to drain the buffer (level, sampled in FILL).
- out_data, output, WIDTH*OUT_ELEMS, element 0 in the MSBs.
- out_count, output, MinBitWidth(OUT_ELEMS), valid elements in out_data (OUT_ELEMS except on a padded last word).
- out_last, output, 1, final word of a flush.
- out_valid, output, 1, word present.
- out_ready, input, 1, word consumed when out_valid && out_ready.
- flush_done, output, 1, one-cycle pulse when the flush completes.
- count, output, MinBitWidth(BUF_ELEMS), current buffer occupancy (debug/status).

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous, active-low, deasserted synchronously externally.
- Reset values: count=0, state=FILL, out_valid=0, out_last=0, out_count=0, flush_done=0, out_data=0, buffer contents=0. in_ready=1 combinationally after reset.
- Buffer: an element array. Slot 0 is the oldest element. out_data is always slots 0..OUT_ELEMS-1; slots at or above count are forced to 0.
- in_ready = (state==FILL) && (count <= BUF_ELEMS-IN_ELEMS). It is a function of registered state only; there is no combinational path from out_ready or in_valid.
- Push: on accept, elements 0..in_len-1 are appended at slot count, after any same-cycle pop shift.
  - in_len=0 with in_valid is accepted and changes nothing.
  - in_len>IN_ELEMS is illegal; RTL clamps it to IN_ELEMS.
- Pop: on out_valid && out_ready, the buffer shifts down by OUT_ELEMS, or by count for a padded last word.
- Same cycle: count_next = count - popped + pushed. Both are legal together.
- Latency: an accepted beat is visible on out_data/out_valid after the same rising edge (1 cycle).
- States:
  - FILL: out_valid = (count >= OUT_ELEMS), out_count=OUT_ELEMS, out_last=0. When flush=1, a same-cycle accepted beat is included, then state moves to DRAIN.
  - DRAIN: in_ready=0. While count > OUT_ELEMS, full words are emitted with out_last=0. When 0 < count <= OUT_ELEMS, out_valid=1, out_count=count, pad=0, out_last=1. On that pop, state moves to DONE.
    - A DRAIN entered with count==0 moves to DONE with no output.
    - count==OUT_ELEMS exactly emits a full word with out_last=1.
  - DONE: flush_done=1 for one cycle, out_valid=0, then state returns to FILL. flush is ignored outside FILL.
- Output hold: out_data/out_valid/out_count/out_last hold stable while out_valid && !out_ready.
- Reset mid-operation: buffered data is discarded, all outputs return to reset values immediately (async), and any pending flush is lost.
- Widths: all count arithmetic is done at MinBitWidth(BUF_ELEMS)+1 bits. count never exceeds BUF_ELEMS; the bench asserts this.

Test Plan:
- Reset: assert reset_n=0 mid-stream with count=12 -> out_valid=0, count=0, in_ready=1 immediately. After release, the first push of 8 elements 0xA000..0xA007 appears intact.
- Stream: out_ready=1, one beat len=20 of 0x0001..0x0014 -> out word 0x0001..0x0008 the next cycle, then 0x0009..0x0010; count ends at 4 (0x0011..0x0014), out_valid=0.
- Backpressure: out_ready=0, push len=8 then len=5 -> count=8 with in_ready=1, then count=13 with in_ready=0. Raise out_ready -> word of the first 8 elements, count=5, in_ready=1.
- Simultaneous push/pop: count=8, out_ready=1, push len=20 in the same cycle -> pop 8, count=20, next word equals the first 8 of the new beat.
- Flush with residue: count=4 (0x0011..0x0014), flush=1 -> out_data=0x0011,0x0012,0x0013,0x0014,0,0,0,0, out_count=4, out_last=1. Then flush_done pulses, and in_ready=1 the cycle after.
- Flush while empty: count=0, flush=1 -> no out_valid, flush_done pulse 2 cycles later. Flush with count=16 -> two full words, the second carrying out_last=1 and out_count=8.

Source files
------------

// File: rtl/merge_packer.sv
// Repacks variable-length merge beats (up to IN_ELEMS) into fixed OUT_ELEMS words; flush drains a zero-padded last word.
// Latency: accepted beat visible on the output after one edge; in_ready depends on registered state only, output holds while stalled.
module merge_packer #(
  parameter  int WIDTH     = 16,
  parameter  int IN_ELEMS  = 20,
  parameter  int OUT_ELEMS = 8,
  localparam int BUF_ELEMS = IN_ELEMS + OUT_ELEMS,
  localparam int LW        = $clog2(IN_ELEMS + 1),
  localparam int OW        = $clog2(OUT_ELEMS + 1),
  localparam int CW        = $clog2(BUF_ELEMS + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [WIDTH*IN_ELEMS-1:0]  in_data,
  input  logic [LW-1:0]              in_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [WIDTH*OUT_ELEMS-1:0] out_data,
  output logic [OW-1:0]              out_count,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       flush_done,
  output logic [CW-1:0]              count
);

  localparam int            AW     = CW + 1;
  localparam logic [AW-1:0] OUT_A  = AW'(OUT_ELEMS);
  localparam logic [AW-1:0] IN_A   = AW'(IN_ELEMS);
  localparam logic [AW-1:0] ROOM_A = AW'(BUF_ELEMS - IN_ELEMS);

  typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [BUF_ELEMS];
  logic [WIDTH-1:0] mem_d [BUF_ELEMS];
  logic [AW-1:0]    cnt_q, cnt_d, len_c, pop_n, push_n, base;
  logic             pop, push, last_w;

  assign count    = cnt_q[CW-1:0];
  assign len_c    = (AW'(in_len) > IN_A) ? IN_A : AW'(in_len);
  assign in_ready = (state_q == FILL) && (cnt_q <= ROOM_A);
  assign push     = in_valid && in_ready;
  assign push_n   = push ? len_c : '0;

  always_comb begin
    state_d    = state_q;
    out_valid  = 1'b0;
    last_w     = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      FILL: begin
        out_valid = (cnt_q >= OUT_A);
        if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q > OUT_A) begin
          out_valid = 1'b1;
        end else if (cnt_q != '0) begin
          out_valid = 1'b1;
          last_w    = 1'b1;
          if (out_ready) state_d = DONE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign out_last  = last_w;
  assign out_count = !out_valid ? '0 : (last_w ? OW'(cnt_q) : OW'(OUT_ELEMS));
  assign pop       = out_valid && out_ready;
  assign pop_n     = !pop ? '0 : (last_w ? cnt_q : OUT_A);
  assign base      = cnt_q - pop_n;
  assign cnt_d     = base + push_n;

  // Shift out the popped elements first, then append the new beat at the post-pop occupancy.
  always_comb begin
    for (int i = 0; i < BUF_ELEMS; i++) begin
      mem_d[i] = '0;
      for (int j = 0; j < BUF_ELEMS; j++) begin
        if (j == i + int'(pop_n)) mem_d[i] = mem_q[j];
      end
      for (int k = 0; k < IN_ELEMS; k++) begin
        if (push && (k < int'(len_c)) && (i == int'(base) + k))
          mem_d[i] = in_data[WIDTH*(IN_ELEMS-k)-1 -: WIDTH];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int e = 0; e < OUT_ELEMS; e++) begin
      if (AW'(e) < cnt_q) out_data[WIDTH*(OUT_ELEMS-e)-1 -: WIDTH] = mem_q[e];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      for (int i = 0; i < BUF_ELEMS; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_merge_packer.sv
// Bench for merge_packer: directed scenarios plus random traffic against a queue-based reference model.
module tb_merge_packer;

  localparam int W  = 16;
  localparam int NI = 20;
  localparam int NO = 8;
  localparam int NB = 28;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [NI*W-1:0] in_data;
  logic [4:0]     in_len;
  logic           in_valid, in_ready, flush;
  logic [NO*W-1:0] out_data;
  logic [3:0]     out_count;
  logic           out_last, out_valid, out_ready, flush_done;
  logic [4:0]     count;

  merge_packer dut (
    .clock(clock), .reset_n(reset_n),
    .in_data(in_data), .in_len(in_len), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .out_data(out_data), .out_count(out_count), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .flush_done(flush_done), .count(count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: queue of buffered elements plus flush phase (0 fill, 1 drain, 2 done).
  logic [15:0] q[$];
  int          phase = 0;
  logic        e_rdy, e_vld, e_last, e_done;
  int          e_cnt;
  logic [127:0] e_data;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_outs();
    int sz;
    sz     = q.size();
    e_rdy  = (phase == 0) && (sz <= NB - NI);
    e_vld  = 1'b0;
    e_last = 1'b0;
    e_done = (phase == 2);
    e_cnt  = NO;
    if (phase == 0) e_vld = (sz >= NO);
    else if (phase == 1 && sz > 0) begin
      e_vld = 1'b1;
      if (sz <= NO) begin
        e_last = 1'b1;
        e_cnt  = sz;
      end
    end
    e_data = '0;
    for (int e = 0; e < NO; e++)
      if (e < sz) e_data[W*(NO-e)-1 -: W] = q[e];
  endtask

  task automatic check_outs(input string tag);
    model_outs();
    chk({tag, ".count"},      128'(count),      128'(q.size()));
    chk({tag, ".cap"},        128'(count <= 5'd28), 128'(1));
    chk({tag, ".in_ready"},   128'(in_ready),   128'(e_rdy));
    chk({tag, ".out_valid"},  128'(out_valid),  128'(e_vld));
    chk({tag, ".flush_done"}, 128'(flush_done), 128'(e_done));
    if (e_vld) begin
      chk({tag, ".out_data"},  128'(out_data),  e_data);
      chk({tag, ".out_count"}, 128'(out_count), 128'(e_cnt));
      chk({tag, ".out_last"},  128'(out_last),  128'(e_last));
    end
  endtask

  task automatic step(input logic v, input int len, input logic fl, input logic ordy,
                      input logic [NI*W-1:0] dat, input string tag);
    int n;
    bit acc, pp;
    in_valid  = v;
    in_len    = len[4:0];
    flush     = fl;
    out_ready = ordy;
    in_data   = dat;
    model_outs();
    acc = v && e_rdy;
    pp  = e_vld && ordy;
    @(posedge clock);
    #1;
    if (pp) repeat (e_cnt) void'(q.pop_front());
    if (acc) begin
      n = (len > NI) ? NI : len;
      for (int k = 0; k < n; k++) q.push_back(dat[W*(NI-k)-1 -: W]);
    end
    case (phase)
      0: if (fl) phase = 1;
      1: if (!e_vld || (e_last && pp)) phase = 2;
      default: phase = 0;
    endcase
    check_outs(tag);
  endtask

  task automatic idle(input logic ordy, input string tag);
    step(1'b0, 0, 1'b0, ordy, '0, tag);
  endtask

  function automatic logic [NI*W-1:0] seq(input int base, input int n);
    logic [NI*W-1:0] d;
    for (int k = 0; k < NI; k++)
      d[W*(NI-k)-1 -: W] = (k < n) ? 16'(base + k) : 16'($urandom());
    return d;
  endfunction

  task automatic drain(input string tag);
    step(1'b0, 0, 1'b1, 1'b1, '0, tag);
    for (int i = 0; i < 12 && phase != 0; i++) idle(1'b1, tag);
    chk({tag, ".idle"}, 128'(in_ready && !out_valid && count == 5'd0), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] w;
    in_valid = 1'b0; in_len = '0; flush = 1'b0; out_ready = 1'b0; in_data = '0;

    #12;
    check_outs("rst");
    chk("rst.out_data",  128'(out_data),  128'(0));
    chk("rst.out_count", 128'(out_count), 128'(0));
    chk("rst.out_last",  128'(out_last),  128'(0));
    @(negedge clock) reset_n = 1'b1;

    step(1'b1, 20, 1'b0, 1'b1, seq(1, 20), "stream0");
    w = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    chk("stream.w0", 128'(out_data), w);
    idle(1'b1, "stream1");
    w = 128'h0009_000a_000b_000c_000d_000e_000f_0010;
    chk("stream.w1", 128'(out_data), w);
    idle(1'b1, "stream2");
    chk("stream.cnt", 128'(count), 128'(4));

    step(1'b0, 0, 1'b1, 1'b1, '0, "flushres");
    w = 128'h0011_0012_0013_0014_0000_0000_0000_0000;
    chk("flushres.data",  128'(out_data),  w);
    chk("flushres.ocnt",  128'(out_count), 128'(4));
    chk("flushres.last",  128'(out_last),  128'(1));
    idle(1'b1, "flushres.pop");
    chk("flushres.done",  128'(flush_done), 128'(1));
    idle(1'b1, "flushres.fill");
    chk("flushres.rdy",   128'(in_ready),   128'(1));

    step(1'b1, 8, 1'b0, 1'b0, seq('h20, 8), "bp0");
    chk("bp0.rdy", 128'(in_ready), 128'(1));
    step(1'b1, 5, 1'b0, 1'b0, seq('h30, 5), "bp1");
    chk("bp1.cnt", 128'(count), 128'(13));
    chk("bp1.rdy", 128'(in_ready), 128'(0));
    idle(1'b0, "bp.hold");
    w = 128'h0020_0021_0022_0023_0024_0025_0026_0027;
    chk("bp.hold.data", 128'(out_data), w);
    step(1'b1, 5, 1'b0, 1'b1, seq('h40, 5), "bp2");
    chk("bp2.cnt", 128'(count), 128'(5));

    step(1'b1, 3, 1'b0, 1'b0, seq('h50, 3), "sim0");
    step(1'b1, 20, 1'b0, 1'b1, seq('h100, 20), "sim1");
    chk("sim1.cnt", 128'(count), 128'(20));
    w = 128'h0100_0101_0102_0103_0104_0105_0106_0107;
    chk("sim1.data", 128'(out_data), w);
    drain("drain0");

    step(1'b0, 0, 1'b1, 1'b0, '0, "eflush0");
    chk("eflush0.vld", 128'(out_valid), 128'(0));
    idle(1'b0, "eflush1");
    chk("eflush1.done", 128'(flush_done), 128'(1));
    idle(1'b0, "eflush2");

    step(1'b1, 8, 1'b0, 1'b0, seq('h200, 8), "f16a");
    step(1'b1, 8, 1'b0, 1'b0, seq('h208, 8), "f16b");
    step(1'b0, 0, 1'b1, 1'b0, '0, "f16c");
    chk("f16c.last", 128'(out_last), 128'(0));
    idle(1'b1, "f16d");
    chk("f16d.last", 128'(out_last),  128'(1));
    chk("f16d.ocnt", 128'(out_count), 128'(8));
    w = 128'h0208_0209_020a_020b_020c_020d_020e_020f;
    chk("f16d.data", 128'(out_data), w);
    idle(1'b1, "f16e");
    idle(1'b1, "f16f");

    step(1'b1, 8, 1'b0, 1'b0, seq('h300, 8), "mrst0");
    step(1'b1, 4, 1'b0, 1'b0, seq('h310, 4), "mrst1");
    chk("mrst.cnt12", 128'(count), 128'(12));
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    phase = 0;
    check_outs("mrst.async");
    chk("mrst.data", 128'(out_data), 128'(0));
    @(negedge clock) reset_n = 1'b1;
    step(1'b1, 8, 1'b0, 1'b0, seq('hA000, 8), "mrst.push");
    w = 128'hA000_A001_A002_A003_A004_A005_A006_A007;
    chk("mrst.push.data", 128'(out_data), w);
    drain("drain1");

    for (int c = 0; c < 600; c++) begin
      logic [NI*W-1:0] d;
      int len;
      for (int k = 0; k < NI; k++) d[W*(NI-k)-1 -: W] = 16'($urandom());
      len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(21, 31)) : int'($urandom_range(0, 20));
      step($urandom_range(0, 9) < 7, len, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6, d, "rand");
    end
    drain("drain2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
